busca_instrucao: RTL and testbench

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao_pkg.sv | 25 ++
 rtl/contador_saturado.sv | 26 ++
 rtl/busca_instrucao.sv | 134 +++++++++++++
 tb/tb_busca_instrucao.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/busca_instrucao_pkg.sv
// Constants shared by the fetch, decode and instruction-memory blocks:
// FSM encoding, halt opcode, opcode field bounds and reset PC.
package busca_instrucao_pkg;

  // Fetch FSM encoding (plain vectors so legacy blocks can compare them too)
  localparam logic [1:0] EST_INIT   = 2'd0;
  localparam logic [1:0] EST_BUSCA  = 2'd1;
  localparam logic [1:0] EST_PARADO = 2'd2;

  // Opcode field position inside a 32-bit instruction word
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Halt opcode and default memory geometry
  localparam logic [OPC_W-1:0] HLT_OPCODE = 5'd18;
  localparam logic [31:0]      PC_RESET   = 32'd1;
  localparam logic [31:0]      PC_LIMITE  = 32'd20;

  // Extracts the opcode field of an instruction word
  function automatic logic [OPC_W-1:0] opcode_de(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module contador_saturado #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_cheio;

  assign w_cheio = (r_cnt == {W{1'b1}});

  // Count enabled events until the counter is full
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_en && !w_cheio)
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: walks the PC through instruction memory, presents
// one registered instruction at a time to decode with a valid/ready style
// handshake, stops on a halt opcode or when running past the last word, and
// accepts redirects from later stages.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter logic [31:0]      PC_INICIAL = PC_RESET,
  parameter logic [31:0]      PC_MAX     = PC_LIMITE,
  parameter logic [OPC_W-1:0] OPCODE_HLT = HLT_OPCODE
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] endereco_mem,
  input  logic [31:0] instrucao_mem,
  input  logic        desvio,
  input  logic [31:0] alvo_desvio,
  input  logic        pronto_dec,
  output logic [31:0] instrucao_out,
  output logic [31:0] pc_out,
  output logic        valida_out,
  output logic        parado,
  output logic        erro_endereco,
  output logic [15:0] contador_busca
);

  logic [1:0]  r_estado;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valida;
  logic        r_erro;

  logic        w_ativo;       // state in which redirects are honoured
  logic        w_slot_livre;  // output register can take a new word
  logic        w_pc_ok;       // pc still inside instruction memory
  logic        w_hlt;         // word at pc is a halt
  logic        w_captura;     // a word is captured this cycle
  logic        w_estouro;     // fetch attempted beyond PC_MAX
  logic [15:0] w_contador;

  assign w_ativo      = (r_estado == EST_BUSCA) || (r_estado == EST_PARADO);
  assign w_slot_livre = !r_valida || pronto_dec;
  // Unsigned compare: a pc that wrapped past 2^32 and lands above PC_MAX
  // is treated exactly like a normal overrun.
  assign w_pc_ok      = (r_pc <= PC_MAX);
  assign w_hlt        = (opcode_de(instrucao_mem) == OPCODE_HLT);
  assign w_captura    = (r_estado == EST_BUSCA) && !desvio && w_slot_livre && w_pc_ok;
  assign w_estouro    = (r_estado == EST_BUSCA) && !desvio && w_slot_livre && !w_pc_ok;

  // FSM: INIT gives memory one clock to preload, BUSCA fetches, PARADO waits
  // for a redirect. Redirects win over everything except INIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= EST_INIT;
    end else begin
      case (r_estado)
        EST_INIT:   r_estado <= EST_BUSCA;
        EST_BUSCA: begin
          if (desvio)
            r_estado <= EST_BUSCA;
          else if (w_estouro || (w_captura && w_hlt))
            r_estado <= EST_PARADO;
        end
        EST_PARADO: begin
          if (desvio)
            r_estado <= EST_BUSCA;
        end
        default:    r_estado <= EST_INIT;
      endcase
    end
  end

  // Program counter: redirect target, or advance after a non-halt capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_pc <= PC_INICIAL;
    else if (w_ativo && desvio)
      r_pc <= alvo_desvio;
    else if (w_captura && !w_hlt)
      r_pc <= r_pc + 32'd1;
  end

  // Output register: captured word and its address; these only move on a
  // capture, so a stall simply holds them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_instr  <= '0;
      r_pc_out <= '0;
    end else if (w_captura) begin
      r_instr  <= instrucao_mem;
      r_pc_out <= r_pc;
    end
  end

  // Valid flag: set on capture, dropped by a redirect or when decode takes
  // the word and nothing replaces it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_valida <= 1'b0;
    else if (w_ativo && desvio)
      r_valida <= 1'b0;
    else if (w_captura)
      r_valida <= 1'b1;
    else if (pronto_dec)
      r_valida <= 1'b0;
  end

  // Sticky address error; a redirect does not clear it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_erro <= 1'b0;
    else if (w_estouro)
      r_erro <= 1'b1;
  end

  contador_saturado #(
    .W (16)
  ) u_contador (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_en    (w_captura),
    .o_cnt   (w_contador)
  );

  assign endereco_mem   = r_pc;
  assign instrucao_out  = r_instr;
  assign pc_out         = r_pc_out;
  assign valida_out     = r_valida;
  assign parado         = (r_estado == EST_PARADO);
  assign erro_endereco  = r_erro;
  assign contador_busca = w_contador;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for the fetch stage with a combinational memory model.
module tb_busca_instrucao;

  logic        clock;
  logic        reset;
  logic [31:0] endereco_mem;
  logic [31:0] instrucao_mem;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic        pronto_dec;
  logic [31:0] instrucao_out;
  logic [31:0] pc_out;
  logic        valida_out;
  logic        parado;
  logic        erro_endereco;
  logic [15:0] contador_busca;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  busca_instrucao dut (
    .clock          (clock),
    .reset          (reset),
    .endereco_mem   (endereco_mem),
    .instrucao_mem  (instrucao_mem),
    .desvio         (desvio),
    .alvo_desvio    (alvo_desvio),
    .pronto_dec     (pronto_dec),
    .instrucao_out  (instrucao_out),
    .pc_out         (pc_out),
    .valida_out     (valida_out),
    .parado         (parado),
    .erro_endereco  (erro_endereco),
    .contador_busca (contador_busca)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign instrucao_mem = (endereco_mem < 32'd64) ? mem[endereco_mem[5:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One active edge, then sample on the falling edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] palavra(input int k, input bit hlt);
    logic [4:0] op;
    op = hlt ? 5'd18 : 5'd1;
    return {op, 27'(k)};
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = palavra(i, 1'b0);
    mem[7] = palavra(7, 1'b1);
    reset = 1'b0; desvio = 1'b0; alvo_desvio = '0; pronto_dec = 1'b1;

    // Reset state
    @(negedge clock);
    chk("rst_valida", 32'(valida_out), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_instr", instrucao_out, 32'd0);
    chk("rst_parado", 32'(parado), 32'd0);
    chk("rst_erro", 32'(erro_endereco), 32'd0);
    chk("rst_cont", 32'(contador_busca), 32'd0);
    chk("rst_end", endereco_mem, 32'd1);

    // Run to halt at word 7
    reset = 1'b1;
    tick();
    chk("init_valida", 32'(valida_out), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("seq_pc_out", pc_out, 32'(k));
      chk("seq_valida", 32'(valida_out), 32'd1);
    end
    chk("hlt_instr", instrucao_out, palavra(7, 1'b1));
    chk("hlt_parado", 32'(parado), 32'd1);
    chk("hlt_cont", 32'(contador_busca), 32'd7);
    chk("hlt_end", endereco_mem, 32'd7);
    tick();
    chk("hlt_consumido", 32'(valida_out), 32'd0);
    chk("hlt_cont_hold", 32'(contador_busca), 32'd7);

    // Redirect out of PARADO
    desvio = 1'b1; alvo_desvio = 32'd1;
    tick();
    desvio = 1'b0;
    chk("par_desvio_parado", 32'(parado), 32'd0);
    chk("par_desvio_valida", 32'(valida_out), 32'd0);
    chk("par_desvio_end", endereco_mem, 32'd1);
    tick();
    chk("par_retoma_pc", pc_out, 32'd1);
    chk("par_retoma_cont", 32'(contador_busca), 32'd8);

    // Stall while address 3 is presented
    tick(); tick();
    chk("stall_pre_pc", pc_out, 32'd3);
    pronto_dec = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("stall_pc_out", pc_out, 32'd3);
    chk("stall_instr", instrucao_out, palavra(3, 1'b0));
    chk("stall_end", endereco_mem, 32'd4);
    chk("stall_valida", 32'(valida_out), 32'd1);
    pronto_dec = 1'b1;
    tick();
    chk("stall_retoma", pc_out, 32'd4);

    // Redirect during a stall
    pronto_dec = 1'b0; desvio = 1'b1; alvo_desvio = 32'd2;
    tick();
    desvio = 1'b0; pronto_dec = 1'b1;
    chk("desvio_valida", 32'(valida_out), 32'd0);
    chk("desvio_end", endereco_mem, 32'd2);
    tick();
    chk("desvio_pc_out", pc_out, 32'd2);
    chk("desvio_instr", instrucao_out, palavra(2, 1'b0));

    // Asynchronous reset with pc at 5
    tick(); tick();
    chk("pre_rst_end", endereco_mem, 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("arst_valida", 32'(valida_out), 32'd0);
    chk("arst_pc_out", pc_out, 32'd0);
    chk("arst_instr", instrucao_out, 32'd0);
    chk("arst_cont", 32'(contador_busca), 32'd0);
    chk("arst_end", endereco_mem, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    mem[7] = palavra(7, 1'b0);
    tick();
    chk("arst_init", 32'(valida_out), 32'd0);

    // Overrun past PC_MAX with no halt in memory
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("ovr_pc_out", pc_out, 32'(k));
    end
    chk("ovr_erro_antes", 32'(erro_endereco), 32'd0);
    tick();
    chk("ovr_erro", 32'(erro_endereco), 32'd1);
    chk("ovr_parado", 32'(parado), 32'd1);
    chk("ovr_cont", 32'(contador_busca), 32'd20);
    chk("ovr_valida", 32'(valida_out), 32'd0);
    chk("ovr_pc_hold", pc_out, 32'd20);

    // Redirect keeps the sticky error
    desvio = 1'b1; alvo_desvio = 32'd18;
    tick();
    desvio = 1'b0;
    chk("ovr_desvio_erro", 32'(erro_endereco), 32'd1);
    tick();
    chk("ovr_desvio_pc", pc_out, 32'd18);

    // Wrap: redirect to 2^32-1, next attempt is an overrun
    desvio = 1'b1; alvo_desvio = 32'hFFFF_FFFF;
    tick();
    desvio = 1'b0;
    tick();
    chk("wrap_parado", 32'(parado), 32'd1);
    chk("wrap_pc_hold", pc_out, 32'd18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
